// File: rtl/mfp_prescale_sched.sv
// MFP timer A-D prescaler scheduler, XCLK_I domain, toggle-handshake config.
// Define MFP_PRESCALE_RESTART_EN to clear the channel counter on every write.
module mfp_prescale_sched #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       XCLK_I,
   input  logic       RST,
   input  logic       CFG_REQ,
   input  logic [1:0] CFG_CH,
   input  logic [2:0] CFG_CODE,
   output logic       CFG_ACK,
   output logic [3:0] TICK_TGL,
   output logic [3:0] TICK_PULSE,
   output logic [3:0] ACTIVE
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   req_seen;
   logic                   req_hit;
   logic [2:0]             code [4];
   logic [7:0]             cnt  [4];
   logic [3:0]             wr_sel;
   logic [3:0]             stop_wr;
   logic [3:0]             expire;
   logic [3:0]             clr;

   function automatic logic [7:0] term_of(input logic [2:0] c);
      logic [7:0] t;
      case (c)
         3'd1:    t = 8'd3;
         3'd2:    t = 8'd9;
         3'd3:    t = 8'd15;
         3'd4:    t = 8'd49;
         3'd5:    t = 8'd63;
         3'd6:    t = 8'd99;
         3'd7:    t = 8'd199;
         default: t = 8'd0;
      endcase
      return t;
   endfunction

   assign req_hit = sync[SYNC_STAGES-1] != req_seen;

   // A stop write wins over an expiry landing on the apply edge
   always_comb begin
      wr_sel  = '0;
      stop_wr = '0;
      expire  = '0;
      clr     = '0;
      ACTIVE  = '0;
      for (int i = 0; i < 4; i++) begin
         wr_sel[i]  = req_hit && (CFG_CH == 2'(i));
         stop_wr[i] = wr_sel[i] && (CFG_CODE == 3'd0);
         ACTIVE[i]  = code[i] != 3'd0;
         expire[i]  = ACTIVE[i] && !stop_wr[i]
                   && (cnt[i] >= term_of(code[i]));
`ifdef MFP_PRESCALE_RESTART_EN
         clr[i] = !ACTIVE[i] || expire[i] || wr_sel[i];
`else
         clr[i] = !ACTIVE[i] || expire[i] || stop_wr[i];
`endif
      end
   end

   always_ff @(posedge XCLK_I) begin
      if (RST) begin
         sync       <= '0;
         req_seen   <= 1'b0;
         CFG_ACK    <= 1'b0;
         TICK_TGL   <= '0;
         TICK_PULSE <= '0;
         for (int i = 0; i < 4; i++) begin
            code[i] <= '0;
            cnt[i]  <= '0;
         end
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], CFG_REQ};
         TICK_PULSE <= expire;
         TICK_TGL   <= TICK_TGL ^ expire;
         if (req_hit) begin
            req_seen <= sync[SYNC_STAGES-1];
            CFG_ACK  <= ~CFG_ACK;
         end
         for (int i = 0; i < 4; i++) begin
            if (wr_sel[i])
               code[i] <= CFG_CODE;
            if (clr[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mfp_prescale_sched.sv
// Scoreboard bench for mfp_prescale_sched: expected expiry edges are
// queued per channel when a request is sent and matched on TICK_PULSE.
module tb_mfp_prescale_sched;

   localparam int SS  = 2;
   localparam int HOR = 3000;

   logic       XCLK_I = 1'b0;
   logic       RST;
   logic       CFG_REQ;
   logic [1:0] CFG_CH;
   logic [2:0] CFG_CODE;
   logic       CFG_ACK;
   logic [3:0] TICK_TGL;
   logic [3:0] TICK_PULSE;
   logic [3:0] ACTIVE;

   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         sbq [4][$];
   int         mcode [4];
   int         base  [4];
   logic [3:0] exp_tgl = '0;

   mfp_prescale_sched #(.SYNC_STAGES(SS)) dut (
      .XCLK_I    (XCLK_I),
      .RST       (RST),
      .CFG_REQ   (CFG_REQ),
      .CFG_CH    (CFG_CH),
      .CFG_CODE  (CFG_CODE),
      .CFG_ACK   (CFG_ACK),
      .TICK_TGL  (TICK_TGL),
      .TICK_PULSE(TICK_PULSE),
      .ACTIVE    (ACTIVE)
   );

   always #5 XCLK_I = ~XCLK_I;

   always @(posedge XCLK_I) cyc <= cyc + 1;

   task automatic chk(string tag, int obs, int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   function automatic int term_of(int c);
      case (c)
         1: return 3;
         2: return 9;
         3: return 15;
         4: return 49;
         5: return 63;
         6: return 99;
         7: return 199;
         default: return 0;
      endcase
   endfunction

   task automatic trunc(int ch, int lim);
      while (sbq[ch].size() > 0 && sbq[ch][sbq[ch].size()-1] >= lim)
         void'(sbq[ch].pop_back());
   endtask

   // Predict expiries for a write applied at edge a
   task automatic model_apply(int ch, int code, int a);
      int c, p, t, first, d;
      c = 0;
      if (mcode[ch] != 0) begin
         p = term_of(mcode[ch]) + 1;
         c = ((a - base[ch]) % p + p) % p;
      end
`ifdef MFP_PRESCALE_RESTART_EN
      c = 0;
`endif
      if (code == 0) begin
         trunc(ch, a);
         mcode[ch] = 0;
      end else begin
         trunc(ch, a + 1);
         t = term_of(code);
         d = t - c + 1;
         first = a + ((d > 1) ? d : 1);
         for (int e = first; e < a + HOR; e += t + 1)
            sbq[ch].push_back(e);
         base[ch]  = first;
         mcode[ch] = code;
      end
   endtask

   task automatic wait_ack(int a, int ch, int code);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 12 && !got; n++) begin
         @(negedge XCLK_I);
         if (CFG_ACK == CFG_REQ) got = 1'b1;
      end
      chk("ack_seen", int'(got), 1);
      if (got) chk("ack_edge", cyc, a);
      chk("active", int'(ACTIVE[ch]), (code != 0) ? 1 : 0);
   endtask

   task automatic send(int ch, int code);
      int a;
      a = cyc + SS + 1;
      model_apply(ch, code, a);
      CFG_CH   = 2'(ch);
      CFG_CODE = 3'(code);
      CFG_REQ  = ~CFG_REQ;
      wait_ack(a, ch, code);
   endtask

   task automatic wait_until(int c);
      while (cyc < c) @(negedge XCLK_I);
   endtask

   always @(negedge XCLK_I) begin
      for (int ch = 0; ch < 4; ch++) begin
         while (sbq[ch].size() > 0 && sbq[ch][0] < cyc) begin
            chk($sformatf("missed%0d", ch), cyc, sbq[ch][0]);
            void'(sbq[ch].pop_front());
         end
         if (sbq[ch].size() > 0 && sbq[ch][0] == cyc) begin
            void'(sbq[ch].pop_front());
            exp_tgl[ch] = ~exp_tgl[ch];
            chk($sformatf("pulse%0d", ch), int'(TICK_PULSE[ch]), 1);
            chk($sformatf("tgl%0d", ch), int'(TICK_TGL[ch]),
                int'(exp_tgl[ch]));
         end else if (TICK_PULSE[ch]) begin
            chk($sformatf("spurious%0d", ch), int'(TICK_PULSE[ch]), 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, r;
      for (int i = 0; i < 4; i++) begin
         mcode[i] = 0;
         base[i]  = 0;
      end
      RST      = 1'b1;
      CFG_REQ  = 1'b0;
      CFG_CH   = 2'd0;
      CFG_CODE = 3'd0;
      repeat (3) @(negedge XCLK_I);
      chk("rst_tgl", int'(TICK_TGL), 0);
      chk("rst_pulse", int'(TICK_PULSE), 0);
      chk("rst_active", int'(ACTIVE), 0);
      chk("rst_ack", int'(CFG_ACK), 0);
      RST = 1'b0;
      @(negedge XCLK_I);

      // ch A code 1
      send(0, 1);
      repeat (40) @(negedge XCLK_I);

      // ch B walks through every code
      for (int c = 1; c <= 7; c++) begin
         send(1, c);
         repeat (2 * (term_of(c) + 1) + 5) @(negedge XCLK_I);
      end
      send(1, 0);

      // ch C: code 7 to cnt 150, then code 1
      send(2, 7);
      a = cyc;
      wait_until(a + 150 - SS - 1);
      send(2, 1);
      a = cyc;
`ifdef MFP_PRESCALE_RESTART_EN
      wait_until(a + 4);
`else
      wait_until(a + 1);
`endif
      chk("c_first", int'(TICK_PULSE[2]), 1);
      repeat (20) @(negedge XCLK_I);
      send(2, 0);

      // ch D stop and restart
      send(3, 2);
      repeat (30) @(negedge XCLK_I);
      send(3, 0);
      repeat (40) @(negedge XCLK_I);
      chk("d_frozen", int'(TICK_TGL[3]), int'(exp_tgl[3]));
      send(3, 2);
      a = cyc;
      wait_until(a + 9);
      chk("d_early", int'(TICK_PULSE[3]), 0);
      @(negedge XCLK_I);
      chk("d_first", int'(TICK_PULSE[3]), 1);
      repeat (5) @(negedge XCLK_I);

      // all stopped, then code 1 everywhere, phase-aligned
      send(0, 0);
      send(3, 0);
      repeat (5) @(negedge XCLK_I);
      for (int ch = 0; ch < 4; ch++) begin
         send(ch, 1);
         if (ch < 3) @(negedge XCLK_I);
      end
      wait_until(cyc + 4);
      chk("simul", int'(TICK_PULSE), 15);
      repeat (6) @(negedge XCLK_I);

      // reset mid-period with CFG_REQ left high
      RST      = 1'b1;
      CFG_REQ  = 1'b1;
      CFG_CH   = 2'd0;
      CFG_CODE = 3'd1;
      for (int ch = 0; ch < 4; ch++) begin
         trunc(ch, cyc + 1);
         mcode[ch] = 0;
      end
      @(negedge XCLK_I);
      exp_tgl = '0;
      chk("mrst_tgl", int'(TICK_TGL), 0);
      chk("mrst_pulse", int'(TICK_PULSE), 0);
      chk("mrst_active", int'(ACTIVE), 0);
      chk("mrst_ack", int'(CFG_ACK), 0);
      r = cyc;
      RST = 1'b0;
      model_apply(0, 1, r + SS + 1);
      wait_ack(r + SS + 1, 0, 1);
      repeat (20) @(negedge XCLK_I);

      send(0, 0);
      @(negedge XCLK_I);
      for (int ch = 0; ch < 4; ch++)
         chk($sformatf("drain%0d", ch), sbq[ch].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mfp_prescale_sched.md
# mfp_prescale_sched

Prescaler scheduler for the four MFP timer channels (A–D). It runs entirely in the timer crystal domain (XCLK_I). It accepts per-channel prescale codes from the CPU domain through a toggle handshake and produces per-channel prescaler expiry events. The toggle outputs feed each timer's clock-domain edge detector; the pulse outputs serve consumers local to XCLK_I.

## Interface

Parameters:
- SYNC_STAGES, default 2: flops in the CFG_REQ synchronizer (legal values 2–4).

Ports:
- XCLK_I  in  1  timer crystal clock; sole clock of the block.
- RST  in  1  reset; synchronous, active-high, sampled on XCLK_I.
- CFG_REQ  in  1  request toggle from the CPU domain; each level change is one request.
- CFG_CH  in  2  target channel (0=A … 3=D); stable from the CFG_REQ toggle until CFG_ACK toggles.
- CFG_CODE  in  3  prescale code (0 = stop); same stability rule as CFG_CH.
- CFG_ACK  out  1  acknowledge toggle; equals CFG_REQ once the request has been applied.
- TICK_TGL  out  4  per-channel toggle, inverted on each prescaler expiry.
- TICK_PULSE  out  4  per-channel one-XCLK_I-cycle strobe on expiry.
- ACTIVE  out  4  per-channel running flag; `code[i] != 0`, driven from the register.

## Operation

- Per-channel state: `code[i]` (3 bit) and `cnt[i]` (8 bit).
- Terminal value by code:

  | code | term | period (XCLK_I cycles) |
  |---|---|---|
  | 1 | 3 | 4 |
  | 2 | 9 | 10 |
  | 3 | 15 | 16 |
  | 4 | 49 | 50 |
  | 5 | 63 | 64 |
  | 6 | 99 | 100 |
  | 7 | 199 | 200 |

- Each cycle, for each channel:
  - `code==0`: `cnt<=0`, no event. TICK_TGL holds its value.
  - `cnt >= term`: `cnt<=0`, TICK_TGL[i] inverts, TICK_PULSE[i]=1.
  - Otherwise: `cnt<=cnt+1`.
- The comparison is `>=`, not `==`. If a shorter code is written while `cnt` is above the new term, the channel expires on the next cycle; no wrap through 255 occurs.
- Handshake:
  - CFG_REQ passes through SYNC_STAGES flops. A request is detected when `sync_last != req_seen`.
  - On detection: `code[CFG_CH] <= CFG_CODE`, `req_seen <= sync_last`, CFG_ACK inverts.
  - Exactly one request is applied per detected edge. The requester must not toggle CFG_REQ again before CFG_ACK matches it; violating this is a protocol error with undefined result.
- Writing the current code to a channel leaves `cnt` untouched (build without the macro).
- The stopped→running transition starts from `cnt=0`, so the first expiry follows one full period after the apply cycle.
- Channels are independent; all four may expire in the same cycle.

## Timing

- Reset values: all `code`=0, `cnt`=0, TICK_TGL=0000, TICK_PULSE=0000, ACTIVE=0000, CFG_ACK=0, synchronizer flops=0, `req_seen`=0.
- Request latency, when CFG_REQ toggles before XCLK_I edge 1:
  - detection and apply occur at edge SYNC_STAGES+1;
  - CFG_ACK and ACTIVE change at that same edge;
  - the new code governs counting from the following edge.
- Expiry latency: TICK_PULSE and TICK_TGL are registered and change on the same edge as `cnt` returns to 0.
- Steady-state spacing between expiries is exactly `term+1` cycles.
- Reset mid-operation clears everything within one cycle. If CFG_REQ remains 1 after reset, it is treated as a new request. The CPU-side requester must therefore reset its toggle together with this block.
- Stop mid-period: `cnt` clears at the apply edge, with no further pulse.

## Configuration

- Macro: MFP_PRESCALE_RESTART_EN.
- Undefined: `cnt` is cleared only while `code==0`. Changing between non-zero codes keeps the phase, using the `>=` rule.
- Defined: every applied write, including a rewrite of the same code, clears `cnt[CFG_CH]` at the apply edge. The next expiry then occurs exactly `term+1` cycles later. Other channels are unaffected.

## Test plan

- Reset, then write ch A code 1 (SYNC_STAGES=2): CFG_ACK toggles at edge 3; TICK_PULSE[0] fires every 4 cycles; TICK_TGL[0] alternates.
- Codes 1..7 on ch B in turn: measured pulse spacing is 4, 10, 16, 50, 64, 100, 200 cycles.
- Ch C on code 7 at `cnt=150`, then write code 1: pulse on the cycle after apply, then every 4 cycles.
  - With MFP_PRESCALE_RESTART_EN: first pulse 4 cycles after apply.
- Ch D running code 2, write code 0: ACTIVE[3]=0 at the apply edge, no further pulses, TICK_TGL[3] frozen. Restart with code 2: first pulse 10 cycles after apply.
- Four back-to-back requests (one per channel, each waiting for ACK): each acknowledged exactly once; all channels set to code 1 on the same edge pulse simultaneously.
- Assert RST mid-period with CFG_REQ held at 1: all outputs are zero the cycle after RST; a request is applied SYNC_STAGES+1 cycles after RST deasserts.
